// File: rtl/wb_master_if.sv
// Wishbone classic master bridging a stalled CPU pipeline to a single outstanding bus access.
// Completion data and error/timeout flags are held while the pipeline remains stalled.
module wb_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int STALL_W = 6,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [DATA_W-1:0]  cpu_data_i,
    input  logic               cpu_we_i,
    input  logic [SEL_W-1:0]   cpu_sel_i,
    output logic [DATA_W-1:0]  cpu_data_o,
    output logic               stallreq,
    output logic               bus_err_o,
    output logic               bus_tmo_o,
    output logic [ADDR_W-1:0]  wishbone_addr_o,
    output logic [DATA_W-1:0]  wishbone_data_o,
    output logic               wishbone_we_o,
    output logic [SEL_W-1:0]   wishbone_sel_o,
    output logic               wishbone_stb_o,
    output logic               wishbone_cyc_o,
    input  logic [DATA_W-1:0]  wishbone_data_i,
    input  logic               wishbone_ack_i,
    input  logic               wishbone_err_i
);

    localparam logic [1:0] IDLE           = 2'b00;
    localparam logic [1:0] BUSY           = 2'b01;
    localparam logic [1:0] WAIT_FOR_STALL = 2'b10;

    // A zero TIMEOUT still needs a 1-bit timer so the declarations stay legal.
    localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_MAX  = '1;

    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] rd_buf;
    logic              err_flag;
    logic              tmo_flag;
    logic              stb_q;

    logic tmo_hit;
    logic done;
    logic rd_ack;

    assign tmo_hit = (TIMEOUT != 0) && (timer == TMO_LAST);
    assign done    = wishbone_err_i | wishbone_ack_i | tmo_hit;
    assign rd_ack  = wishbone_ack_i & ~wishbone_err_i & ~wishbone_we_o;

    assign wishbone_stb_o = stb_q;
    assign wishbone_cyc_o = stb_q;

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = '0;
        bus_err_o  = 1'b0;
        bus_tmo_o  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: stallreq = cpu_ce_i & ~flush_i;
                BUSY: begin
                    // A flush without completion still stalls; the abort lands at the edge.
                    stallreq   = ~done;
                    cpu_data_o = rd_ack ? wishbone_data_i : '0;
                    bus_err_o  = wishbone_err_i;
                    bus_tmo_o  = tmo_hit & ~wishbone_err_i & ~wishbone_ack_i;
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                    bus_err_o  = err_flag;
                    bus_tmo_o  = tmo_flag;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == 2'b11) begin
            state           <= IDLE;
            timer           <= '0;
            rd_buf          <= '0;
            err_flag        <= 1'b0;
            tmo_flag        <= 1'b0;
            stb_q           <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        state           <= BUSY;
                        stb_q           <= 1'b1;
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        rd_buf          <= '0;
                        err_flag        <= 1'b0;
                        tmo_flag        <= 1'b0;
                        timer           <= '0;
                    end
                end
                BUSY: begin
                    if (done || flush_i) begin
                        stb_q           <= 1'b0;
                        wishbone_addr_o <= '0;
                        wishbone_data_o <= '0;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= '0;
                    end
                    if (done) begin
                        rd_buf   <= rd_ack ? wishbone_data_i : '0;
                        err_flag <= wishbone_err_i;
                        tmo_flag <= tmo_hit & ~wishbone_err_i & ~wishbone_ack_i;
                        state    <= (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
                    end else if (flush_i) begin
                        rd_buf   <= '0;
                        err_flag <= 1'b0;
                        tmo_flag <= 1'b0;
                        state    <= IDLE;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_FOR_STALL: begin
                    if (flush_i || stall_i == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
